// File: rtl/sort_stream_adapter.sv
// sort_stream_adapter
// Handshaked front/back end for the systolic sort core. One frame of SIZE
// words is collected from the input stream into a local buffer. The core is
// then released from reset and fed each word for two cycles. Its ascending
// output burst is captured into the same buffer and replayed on the output
// stream with a last flag. Input and output frames strictly alternate because
// the buffer serves only one phase at a time.

module sort_stream_adapter #(
  parameter int SIZE    = 1024,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 4*SIZE+16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             srt_rst_n,
  output logic [WIDTH-1:0] srt_d,
  input  logic             srt_active_input,
  input  logic             srt_active_output,
  input  logic [WIDTH-1:0] srt_q,
  output logic             err
);

  localparam int AW = $clog2(SIZE);
  localparam int IW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);
  localparam logic [TW-1:0] WD_LIMIT = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_FILL    = 3'd0,
    ST_ARM     = 3'd1,
    ST_FEED    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DRAIN   = 3'd5
  } state_t;

  state_t           state_r, state_nxt_s;
  // One index serves every phase: write in FILL/CAPTURE, read in FEED/DRAIN.
  logic [IW-1:0]    idx_r, idx_nxt_s, idx_inc_s;
  logic             beat_r, beat_nxt_s;
  logic             started_r, started_nxt_s;
  logic [TW-1:0]    wd_r, wd_nxt_s;

  logic             s_ready_r, s_ready_nxt_s;
  logic             m_valid_r, m_valid_nxt_s;
  logic             m_last_r, m_last_nxt_s;
  logic [WIDTH-1:0] m_data_r, m_data_nxt_s;
  logic             srt_rst_n_r, srt_rst_n_nxt_s;
  logic [WIDTH-1:0] srt_d_r, srt_d_nxt_s;
  logic             err_r, err_nxt_s;

  logic [WIDTH-1:0] mem_r [SIZE];
  logic             mem_we_s;
  logic [AW-1:0]    mem_waddr_s;
  logic [WIDTH-1:0] mem_wdata_s;
  logic [AW-1:0]    mem_raddr_s;
  logic [WIDTH-1:0] mem_rdata_s;

  assign idx_inc_s   = idx_r + {{(IW-1){1'b0}}, 1'b1};
  assign mem_rdata_s = mem_r[mem_raddr_s];

  assign s_ready   = s_ready_r;
  assign m_valid   = m_valid_r;
  assign m_last    = m_last_r;
  assign m_data    = m_data_r;
  assign srt_rst_n = srt_rst_n_r;
  assign srt_d     = srt_d_r;
  assign err       = err_r;

  // Read address: word 0 when starting the feed or preloading the drain, else the next word.
  always_comb begin
    if (((state_r == ST_FEED) && !started_r) || (state_r == ST_CAPTURE)) begin
      mem_raddr_s = {AW{1'b0}};
    end else begin
      mem_raddr_s = idx_inc_s[AW-1:0];
    end
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_nxt_s     = state_r;
    idx_nxt_s       = idx_r;
    beat_nxt_s      = beat_r;
    started_nxt_s   = started_r;
    wd_nxt_s        = wd_r;
    s_ready_nxt_s   = 1'b0;
    m_valid_nxt_s   = m_valid_r;
    m_last_nxt_s    = m_last_r;
    m_data_nxt_s    = m_data_r;
    srt_rst_n_nxt_s = srt_rst_n_r;
    srt_d_nxt_s     = srt_d_r;
    err_nxt_s       = err_r;
    mem_we_s        = 1'b0;
    mem_waddr_s     = idx_r[AW-1:0];
    mem_wdata_s     = s_data;

    case (state_r)
      ST_FILL: begin
        s_ready_nxt_s   = 1'b1;
        srt_rst_n_nxt_s = 1'b0;
        srt_d_nxt_s     = {WIDTH{1'b0}};
        if (s_valid && s_ready_r) begin
          mem_we_s = 1'b1;
          if (idx_r == LAST_IDX) begin
            idx_nxt_s     = {IW{1'b0}};
            s_ready_nxt_s = 1'b0;
            state_nxt_s   = ST_ARM;
          end else begin
            idx_nxt_s = idx_inc_s;
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end

      ST_ARM: begin
        srt_rst_n_nxt_s = 1'b1;
        started_nxt_s   = 1'b0;
        beat_nxt_s      = 1'b0;
        idx_nxt_s       = {IW{1'b0}};
        state_nxt_s     = ST_FEED;
      end

      ST_FEED: begin
        if (!started_r) begin
          // Hold zero until the core opens its input window, then never look at it again.
          if (srt_active_input) begin
            started_nxt_s = 1'b1;
            beat_nxt_s    = 1'b0;
            idx_nxt_s     = {IW{1'b0}};
            srt_d_nxt_s   = mem_rdata_s;
          end else begin
            srt_d_nxt_s = {WIDTH{1'b0}};
          end
        end else if (beat_r == 1'b0) begin
          beat_nxt_s = 1'b1;
        end else if (idx_r == LAST_IDX) begin
          srt_d_nxt_s = {WIDTH{1'b0}};
          idx_nxt_s   = {IW{1'b0}};
          wd_nxt_s    = {TW{1'b0}};
          state_nxt_s = ST_WAIT;
        end else begin
          idx_nxt_s   = idx_inc_s;
          beat_nxt_s  = 1'b0;
          srt_d_nxt_s = mem_rdata_s;
        end
      end

      ST_WAIT: begin
        if (srt_active_output) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = {AW{1'b0}};
          mem_wdata_s = srt_q;
          idx_nxt_s   = {{(IW-1){1'b0}}, 1'b1};
          state_nxt_s = ST_CAPTURE;
        end else if (wd_r == WD_LIMIT) begin
          // Core never answered: drop the frame and hold the core in reset again.
          err_nxt_s       = 1'b1;
          srt_rst_n_nxt_s = 1'b0;
          idx_nxt_s       = {IW{1'b0}};
          state_nxt_s     = ST_FILL;
        end else begin
          wd_nxt_s = wd_r + {{(TW-1){1'b0}}, 1'b1};
        end
      end

      ST_CAPTURE: begin
        if (srt_active_output) begin
          mem_we_s    = 1'b1;
          mem_wdata_s = srt_q;
          if (idx_r == LAST_IDX) begin
            srt_rst_n_nxt_s = 1'b0;
            idx_nxt_s       = {IW{1'b0}};
            m_valid_nxt_s   = 1'b1;
            m_data_nxt_s    = mem_rdata_s;
            m_last_nxt_s    = 1'b0;
            state_nxt_s     = ST_DRAIN;
          end else begin
            idx_nxt_s = idx_inc_s;
          end
        end else begin
          // Burst ended early: flag it and replay whatever the buffer holds.
          err_nxt_s       = 1'b1;
          srt_rst_n_nxt_s = 1'b0;
          idx_nxt_s       = {IW{1'b0}};
          m_valid_nxt_s   = 1'b1;
          m_data_nxt_s    = mem_rdata_s;
          m_last_nxt_s    = 1'b0;
          state_nxt_s     = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (m_valid_r && m_ready) begin
          if (idx_r == LAST_IDX) begin
            m_valid_nxt_s = 1'b0;
            m_data_nxt_s  = {WIDTH{1'b0}};
            m_last_nxt_s  = 1'b0;
            idx_nxt_s     = {IW{1'b0}};
            state_nxt_s   = ST_FILL;
          end else begin
            idx_nxt_s    = idx_inc_s;
            m_data_nxt_s = mem_rdata_s;
            m_last_nxt_s = (idx_inc_s == LAST_IDX);
          end
        end else begin
          m_data_nxt_s = m_data_r;
        end
      end

      default: begin
        state_nxt_s     = ST_FILL;
        idx_nxt_s       = {IW{1'b0}};
        srt_rst_n_nxt_s = 1'b0;
        srt_d_nxt_s     = {WIDTH{1'b0}};
        m_valid_nxt_s   = 1'b0;
        m_last_nxt_s    = 1'b0;
        m_data_nxt_s    = {WIDTH{1'b0}};
      end
    endcase
  end

  // State, counters and registered outputs; reset holds the core in reset with all outputs low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_FILL;
      idx_r       <= {IW{1'b0}};
      beat_r      <= 1'b0;
      started_r   <= 1'b0;
      wd_r        <= {TW{1'b0}};
      s_ready_r   <= 1'b0;
      m_valid_r   <= 1'b0;
      m_last_r    <= 1'b0;
      m_data_r    <= {WIDTH{1'b0}};
      srt_rst_n_r <= 1'b0;
      srt_d_r     <= {WIDTH{1'b0}};
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      beat_r      <= beat_nxt_s;
      started_r   <= started_nxt_s;
      wd_r        <= wd_nxt_s;
      s_ready_r   <= s_ready_nxt_s;
      m_valid_r   <= m_valid_nxt_s;
      m_last_r    <= m_last_nxt_s;
      m_data_r    <= m_data_nxt_s;
      srt_rst_n_r <= srt_rst_n_nxt_s;
      srt_d_r     <= srt_d_nxt_s;
      err_r       <= err_nxt_s;
    end
  end

  // Frame buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

endmodule

// File: tb/tb_sort_stream_adapter.sv
// Bench for sort_stream_adapter with a behavioural sort core, input/feed and
// output scoreboards, a table of normal frames and hand-written corner cases.

module tb_sort_stream_adapter;

  localparam int SIZE    = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 32;
  localparam int PER     = 10;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic [WIDTH-1:0] s_data  = 8'd0;
  logic             s_valid = 1'b0;
  logic             m_ready = 1'b0;
  logic             act_in  = 1'b0;
  logic             act_out = 1'b0;
  logic [WIDTH-1:0] srt_q   = 8'd0;
  logic             s_ready, m_valid, m_last, srt_rst_n, err;
  logic [WIDTH-1:0] m_data, srt_d;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             l;
  } exp_t;

  typedef struct {
    logic [3:0][WIDTH-1:0] w;
    logic [3:0][WIDTH-1:0] e;
    bit                    tog;
    int                    stall;
    bit                    wait_done;
  } vec_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] feed_q[$];
  vec_t             tbl[5];

  int n_pass  = 0;
  int n_total = 0;

  int  cm_mode = 0;
  int  cm_st   = 0;
  int  cm_cnt  = 0;
  int  cm_n    = 0;
  int  cm_oidx = 0;
  logic [WIDTH-1:0] cm_w[SIZE];
  time wait_t  = 0;

  int   stall_n    = 0;
  int   rdy_cnt    = 0;
  bit   prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = 8'd0;
  logic prev_last  = 1'b0;
  bit   saw_mvalid = 1'b0;
  int   low_cnt    = 0;
  int   last_low   = 0;

  always #(PER/2) clk = ~clk;

  sort_stream_adapter #(.SIZE(SIZE), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .srt_rst_n(srt_rst_n), .srt_d(srt_d),
    .srt_active_input(act_in), .srt_active_output(act_out), .srt_q(srt_q),
    .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Core model (sync reset, 2-cycle input window then output burst) and output monitor.
  always @(negedge clk) begin : core_and_monitor
    logic [WIDTH-1:0] tmp;
    exp_t e;
    bit   rdy;
    int   lim;
    if (!srt_rst_n) begin
      cm_st = 0; cm_cnt = 0; cm_n = 0;
      act_in = 1'b0; act_out = 1'b0; srt_q = 8'd0;
    end else begin
      case (cm_st)
        0: begin cm_cnt = 0; cm_n = 0; cm_st = 1; end
        1: begin
          chk("srt_d_before_window", srt_d, 0);
          cm_cnt++;
          if (cm_cnt == 2) begin act_in = 1'b1; cm_cnt = 0; cm_st = 2; end
        end
        2: begin
          if (feed_q.size() == 0) chk("srt_d_extra_feed", srt_d, 32'hFFFF);
          else begin
            chk("srt_d_feed", srt_d, feed_q[0]);
            if (cm_n % 2 == 1) void'(feed_q.pop_front());
          end
          if (cm_n % 2 == 1) cm_w[cm_n/2] = srt_d;
          cm_n++;
          if (cm_n == SIZE) act_in = 1'b0;
          if (cm_n == 2*SIZE) begin
            for (int a = 0; a < SIZE-1; a++)
              for (int b = 0; b < SIZE-1-a; b++)
                if (cm_w[b] > cm_w[b+1]) begin
                  tmp = cm_w[b]; cm_w[b] = cm_w[b+1]; cm_w[b+1] = tmp;
                end
            cm_cnt = 0; cm_st = 3;
          end
        end
        3: begin
          if (cm_cnt == 0) begin
            wait_t = $time;
            chk("srt_d_after_feed", srt_d, 0);
          end
          cm_cnt++;
          if (cm_mode != 1 && cm_cnt == 2) begin
            act_out = 1'b1; srt_q = cm_w[0]; cm_oidx = 1; cm_st = 4;
          end
        end
        4: begin
          lim = (cm_mode == 2) ? 2 : SIZE;
          if (cm_oidx == lim) begin
            act_out = 1'b0; srt_q = 8'd0; cm_st = 5;
          end else begin
            srt_q = cm_w[cm_oidx]; cm_oidx++;
          end
        end
        default: ;
      endcase
    end

    if (!srt_rst_n) low_cnt++;
    else begin
      if (low_cnt > 0) last_low = low_cnt;
      low_cnt = 0;
    end

    if (!rst_n) begin
      m_ready = 1'b0; prev_stall = 1'b0; rdy_cnt = 0;
    end else if (m_valid) begin
      saw_mvalid = 1'b1;
      chk("s_ready_low_in_drain", s_ready, 0);
      if (prev_stall) begin
        chk("m_data_stable", m_data, prev_data);
        chk("m_last_stable", m_last, prev_last);
      end
      rdy = (rdy_cnt >= stall_n);
      m_ready = rdy;
      if (rdy) begin
        if (exp_q.size() == 0) chk("unexpected_output", m_data, 32'hFFFF);
        else begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e.d);
          chk("m_last", m_last, e.l);
        end
        rdy_cnt = 0;
      end else rdy_cnt++;
      prev_stall = !rdy;
      prev_data  = m_data;
      prev_last  = m_last;
    end else begin
      m_ready = (stall_n == 0);
      prev_stall = 1'b0;
    end
  end

  task automatic set_vec(input int i, input logic [3:0][WIDTH-1:0] w,
                         input logic [3:0][WIDTH-1:0] e, input bit tog,
                         input int stall, input bit wd);
    tbl[i].w = w; tbl[i].e = e; tbl[i].tog = tog; tbl[i].stall = stall; tbl[i].wait_done = wd;
  endtask

  task automatic send_frame(input logic [3:0][WIDTH-1:0] w, input bit tog);
    int idx = 0;
    int guard = 0;
    bit ph = 1'b0;
    bit v;
    while (idx < SIZE && guard < 2000) begin
      @(negedge clk);
      guard++;
      v = tog ? ph : 1'b1;
      ph = ~ph;
      s_valid = v;
      s_data  = v ? w[idx] : 8'hA5;
      if (v && s_ready) begin
        feed_q.push_back(w[idx]);
        idx++;
      end
    end
    if (idx < SIZE) chk("send_timeout", idx, SIZE);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || m_valid) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) chk("drain_timeout", g, 0);
  endtask

  task automatic push_exp(input logic [3:0][WIDTH-1:0] e);
    for (int k = 0; k < SIZE; k++) exp_q.push_back('{d: e[k], l: (k == SIZE-1)});
  endtask

  task automatic run_entry(input int i);
    stall_n = tbl[i].stall;
    cm_mode = 0;
    push_exp(tbl[i].e);
    send_frame(tbl[i].w, tbl[i].tog);
    if (tbl[i].wait_done) begin
      wait_drain();
      chk("err_clear", err, 0);
      chk("srt_rst_n_low_run_ge4", (last_low >= 4), 1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_srt_rst_n"}, srt_rst_n, 0);
    chk({tag, "_srt_d"}, srt_d, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin : main
    time err_t;
    int  g;
    // inputs (word 0 in the low byte), expected sorted output, toggle, stall, wait
    set_vec(0, {8'd1, 8'd9, 8'd3, 8'd7},   {8'd9, 8'd7, 8'd3, 8'd1},   1'b0, 0, 1'b1);
    set_vec(1, {8'd255, 8'd0, 8'd5, 8'd5}, {8'd255, 8'd5, 8'd5, 8'd0}, 1'b1, 3, 1'b1);
    set_vec(2, {8'd6, 8'd8, 8'd2, 8'd4},   {8'd8, 8'd6, 8'd4, 8'd2},   1'b0, 0, 1'b0);
    set_vec(3, {8'd1, 8'd1, 8'd1, 8'd1},   {8'd1, 8'd1, 8'd1, 8'd1},   1'b0, 1, 1'b1);
    set_vec(4, {8'd6, 8'd7, 8'd8, 8'd9},   {8'd9, 8'd8, 8'd7, 8'd6},   1'b0, 0, 1'b1);

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_after_reset", s_ready, 1);

    for (int i = 0; i < 4; i++) run_entry(i);

    // Silent core: watchdog fires TIMEOUT cycles after WAIT entry, frame dropped.
    apply_reset();
    cm_mode = 1; stall_n = 0; saw_mvalid = 1'b0;
    send_frame({8'd40, 8'd30, 8'd20, 8'd10}, 1'b0);
    g = 0;
    while (!err && g < 400) begin @(negedge clk); g++; end
    if (g >= 400) chk("timeout_err_never", err, 1);
    else begin
      err_t = $time;
      chk("timeout_cycles", 32'((err_t - wait_t) / PER), TIMEOUT);
      chk("timeout_srt_rst_n", srt_rst_n, 0);
    end
    g = 0;
    while (!s_ready && g < 50) begin @(negedge clk); g++; end
    chk("timeout_back_to_fill", s_ready, 1);
    repeat (20) @(negedge clk);
    chk("timeout_no_m_valid", saw_mvalid, 0);
    chk("timeout_err_sticky", err, 1);

    // Core stops after 2 words: stale buffer entries are replayed, err set.
    apply_reset();
    cm_mode = 2; stall_n = 0;
    push_exp({8'd20, 8'd30, 8'd20, 8'd10});
    send_frame({8'd20, 8'd30, 8'd10, 8'd40}, 1'b0);
    wait_drain();
    chk("underrun_err", err, 1);

    // Async reset in the middle of the feed, then a clean frame.
    apply_reset();
    cm_mode = 0;
    send_frame({8'd6, 8'd7, 8'd8, 8'd9}, 1'b0);
    g = 0;
    do begin @(negedge clk); #2; g++; end while (cm_n < 3 && g < 200);
    if (g >= 200) chk("midfeed_never_reached", cm_n, 3);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midfeed_reset");
    feed_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_entry(4);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
